c1541_gcr_decode: RTL and testbench
===================================

// Module: c1541_gcr_decode
// PURPOSE
//  Read-side GCR track decoder for the 1541 floppy path: takes the raw GCR bit stream from a
//  G64/track source at the drive bit rate and recovers sector headers and 256-byte data blocks.
//  Hunts SYNC, de-GCRs 10-bit groups into bytes, verifies XOR checksums and writes payload
//  into a sector buffer RAM. It is the inverse of the D64->GCR track encoder.
// PARAMETERS
//  SYNC_BITS   10  consecutive 1 bits that constitute SYNC (must be >= 10)
//  HDR_WINDOW  32  max decoded bytes after a good header within which a data block is accepted
// PORTS
//  clk32       in   1   system clock, 32 MHz
//  reset       in   1   asynchronous, active-high reset
//  enable      in   1   motor on & track source ready; low = decoder idle
//  bit_en      in   1   one-cycle strobe, bit_in valid
//  bit_in      in   1   raw GCR bit, MSB-first
//  sync        out  1   high while in SYNC (>= SYNC_BITS ones seen, no 0 yet)
//  hdr_ok      out  1   pulse: header decoded, checksum good
//  hdr_err     out  1   pulse: header checksum mismatch
//  hdr_track   out  8   track byte of last good header
//  hdr_sector  out  8   sector byte of last good header
//  hdr_id      out  16  {id1,id2} of last good header
//  buf_addr    out  8   sector buffer address
//  buf_di      out  8   sector buffer write data
//  buf_we      out  1   sector buffer write strobe
//  data_ok     out  1   pulse: data block done, checksum good
//  data_err    out  1   pulse: data checksum mismatch or block aborted
//  gcr_err     out  1   pulse: invalid 5-bit GCR code decoded
// BEHAVIOUR
//  - Reset: all outputs 0, state HUNT, counters 0, hdr_armed 0. Async assert, sync release.
//  - enable=0: synchronously force HUNT, clear ones/bit/byte counters and hdr_armed; no pulses.
//  - All work happens only on bit_en cycles; outputs registered, valid the clk32 cycle after
//    the bit_en that completes the event. Pulses are exactly one clk32 wide.
//  - ones counter: +1 on bit 1 (saturate at 15), clear on bit 0. Reaching SYNC_BITS in any
//    state -> SYNC; if state was DATA, pulse data_err (aborted block, no data_ok).
//  - SYNC: first 0 bit leaves SYNC -> ID; that 0 is bit 0 of the first 10-bit group.
//  - Byte assembly: 10 bits MSB-first; bits[9:5] -> high nibble, [4:0] -> low nibble via
//    inverse GCR table (0:01010 1:01011 2:10010 3:10011 4:01110 5:01111 6:10110 7:10111
//    8:01001 9:11001 A:11010 B:11011 C:01101 D:11101 E:11110 F:10101). Other codes decode
//    as 0 and pulse gcr_err (state unchanged; checksum then fails naturally).
//  - ID: 0x08 -> HDR (byte_cnt=0); 0x07 -> DATA (byte_cnt=0, cks=0); else -> HUNT.
//  - HDR: 7 bytes: cks, sector, track, id2, id1, 0x0F, 0x0F. After byte 4 (id1):
//    cks == sector^track^id2^id1 -> latch hdr_*, pulse hdr_ok, hdr_armed=1, window=0;
//    else pulse hdr_err, hdr_armed=0. Trailing 0x0F bytes not checked. Then -> GAP.
//  - GAP/HUNT: each decoded byte while armed increments window; window == HDR_WINDOW
//    clears hdr_armed. Bytes in GAP are discarded.
//  - DATA: bytes 0..255 -> buf_addr=byte_cnt[7:0], buf_di=byte, buf_we=1 only if hdr_armed;
//    cks ^= byte always. Byte 256 = checksum: match -> data_ok, else data_err (pulses only if
//    hdr_armed). Then hdr_armed=0 -> HUNT. Trailing 0x00 0x00 ignored.
//  - byte_cnt 9 bits, no wrap; buf_addr wraps never (max 255).
//  - Simultaneous: sync detection wins over byte completion on the same bit_en.
// TESTING
//  1. Stream 40x'1', header T=18 S=0 id 0x41/0x42, good cks -> sync high, then hdr_ok,
//     hdr_track=0x12, hdr_sector=0x00, hdr_id=0x4142.
//  2. Header with cks corrupted (^0x01) -> hdr_err, no hdr_ok; following data block -> no
//     buf_we, no data_ok/data_err.
//  3. Good header, 8 gap bytes 0x55, sync, data 0x00..0xFF, cks 0x00 -> 256 buf_we with
//     buf_addr==buf_di, then data_ok.
//  4. As 3 but insert 12 ones at data byte 100 -> data_err, state SYNC, 100 writes only.
//  5. Inject GCR 00000 in data byte 5 -> gcr_err pulse, buf_di=0x?0/0x0? at addr 5, data_err.
//  6. Good header, 40 gap bytes (>HDR_WINDOW) then data -> no buf_we; also drop enable and
//     assert reset mid-data -> outputs 0 immediately, decoder restarts in HUNT.

Source files
------------

// File: rtl/c1541_gcr_decode.sv
// Read-side GCR decoder for the 1541 track stream: hunts SYNC, de-GCRs 10-bit groups,
// checks header/data XOR sums and writes recovered sector payload into the buffer RAM.
module c1541_gcr_decode #(
  parameter int unsigned SYNC_BITS  = 10,
  parameter int unsigned HDR_WINDOW = 32
) (
  input  logic        i_clk32,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic        i_bit_en,
  input  logic        i_bit_in,
  output logic        o_sync,
  output logic        o_hdr_ok,
  output logic        o_hdr_err,
  output logic [7:0]  o_hdr_track,
  output logic [7:0]  o_hdr_sector,
  output logic [15:0] o_hdr_id,
  output logic [7:0]  o_buf_addr,
  output logic [7:0]  o_buf_di,
  output logic        o_buf_we,
  output logic        o_data_ok,
  output logic        o_data_err,
  output logic        o_gcr_err
);
  localparam int unsigned WinW = $clog2(HDR_WINDOW + 1);

  typedef enum logic [2:0] {StHunt, StSync, StId, StHdr, StGap, StData} state_t;

  state_t          r_state;
  logic [3:0]      r_ones, r_bit_cnt;
  logic [8:0]      r_shift, r_byte_cnt;
  logic [7:0]      r_cks, r_tmp_sector, r_tmp_track, r_tmp_id2;
  logic [WinW-1:0] r_window;
  logic            r_armed;
  logic            r_sync, r_hdr_ok, r_hdr_err, r_buf_we, r_data_ok, r_data_err, r_gcr_err;
  logic [7:0]      r_hdr_track, r_hdr_sector, r_buf_addr, r_buf_di;
  logic [15:0]     r_hdr_id;

  logic [3:0]      w_ones_nxt;
  logic            w_sync_hit, w_gcr_bad;
  logic [9:0]      w_group;
  logic [4:0]      w_hi, w_lo;
  logic [7:0]      w_byte, w_cks_nxt;
  logic [WinW-1:0] w_window_inc;

  // Returns {valid, nibble}; invalid codes decode as nibble 0.
  function automatic logic [4:0] gcr_dec(input logic [4:0] code);
    case (code)
      5'b01010: gcr_dec = 5'h10;
      5'b01011: gcr_dec = 5'h11;
      5'b10010: gcr_dec = 5'h12;
      5'b10011: gcr_dec = 5'h13;
      5'b01110: gcr_dec = 5'h14;
      5'b01111: gcr_dec = 5'h15;
      5'b10110: gcr_dec = 5'h16;
      5'b10111: gcr_dec = 5'h17;
      5'b01001: gcr_dec = 5'h18;
      5'b11001: gcr_dec = 5'h19;
      5'b11010: gcr_dec = 5'h1A;
      5'b11011: gcr_dec = 5'h1B;
      5'b01101: gcr_dec = 5'h1C;
      5'b11101: gcr_dec = 5'h1D;
      5'b11110: gcr_dec = 5'h1E;
      5'b10101: gcr_dec = 5'h1F;
      default:  gcr_dec = 5'h00;
    endcase
  endfunction

  always_comb begin
    w_ones_nxt = 4'd0;
    if (i_bit_in) w_ones_nxt = (r_ones == 4'hF) ? 4'hF : r_ones + 4'd1;
    w_sync_hit   = i_bit_in && ({28'd0, w_ones_nxt} >= SYNC_BITS);
    w_group      = {r_shift, i_bit_in};
    w_hi         = gcr_dec(w_group[9:5]);
    w_lo         = gcr_dec(w_group[4:0]);
    w_byte       = {w_hi[3:0], w_lo[3:0]};
    w_gcr_bad    = ~(w_hi[4] & w_lo[4]);
    w_cks_nxt    = r_cks ^ w_byte;
    w_window_inc = r_window + WinW'(1);
  end

  always_ff @(posedge i_clk32 or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= StHunt;
      r_ones       <= 4'd0;
      r_bit_cnt    <= 4'd0;
      r_shift      <= 9'd0;
      r_byte_cnt   <= 9'd0;
      r_cks        <= 8'd0;
      r_tmp_sector <= 8'd0;
      r_tmp_track  <= 8'd0;
      r_tmp_id2    <= 8'd0;
      r_window     <= '0;
      r_armed      <= 1'b0;
      r_sync       <= 1'b0;
      r_hdr_ok     <= 1'b0;
      r_hdr_err    <= 1'b0;
      r_hdr_track  <= 8'd0;
      r_hdr_sector <= 8'd0;
      r_hdr_id     <= 16'd0;
      r_buf_addr   <= 8'd0;
      r_buf_di     <= 8'd0;
      r_buf_we     <= 1'b0;
      r_data_ok    <= 1'b0;
      r_data_err   <= 1'b0;
      r_gcr_err    <= 1'b0;
    end else begin
      r_hdr_ok   <= 1'b0;
      r_hdr_err  <= 1'b0;
      r_buf_we   <= 1'b0;
      r_data_ok  <= 1'b0;
      r_data_err <= 1'b0;
      r_gcr_err  <= 1'b0;
      if (!i_enable) begin
        r_state    <= StHunt;
        r_sync     <= 1'b0;
        r_ones     <= 4'd0;
        r_bit_cnt  <= 4'd0;
        r_shift    <= 9'd0;
        r_byte_cnt <= 9'd0;
        r_armed    <= 1'b0;
      end else if (i_bit_en) begin
        r_ones <= w_ones_nxt;
        if (w_sync_hit) begin
          r_data_err <= (r_state == StData);
          r_state    <= StSync;
          r_sync     <= 1'b1;
          r_bit_cnt  <= 4'd0;
        end else if (r_state == StSync) begin
          // Only a 0 reaches here; it is the first bit of the first group.
          r_state   <= StId;
          r_sync    <= 1'b0;
          r_bit_cnt <= 4'd1;
          r_shift   <= 9'd0;
        end else if (r_bit_cnt != 4'd9) begin
          r_shift   <= {r_shift[7:0], i_bit_in};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end else begin
          r_bit_cnt <= 4'd0;
          r_gcr_err <= w_gcr_bad;
          case (r_state)
            StId: begin
              r_byte_cnt <= 9'd0;
              r_cks      <= 8'd0;
              if (w_byte == 8'h08)      r_state <= StHdr;
              else if (w_byte == 8'h07) r_state <= StData;
              else                      r_state <= StHunt;
            end
            StHdr: begin
              r_cks      <= w_cks_nxt;
              r_byte_cnt <= r_byte_cnt + 9'd1;
              case (r_byte_cnt)
                9'd1: r_tmp_sector <= w_byte;
                9'd2: r_tmp_track  <= w_byte;
                9'd3: r_tmp_id2    <= w_byte;
                9'd4: begin
                  if (w_cks_nxt == 8'h00) begin
                    r_hdr_sector <= r_tmp_sector;
                    r_hdr_track  <= r_tmp_track;
                    r_hdr_id     <= {w_byte, r_tmp_id2};
                    r_hdr_ok     <= 1'b1;
                    r_armed      <= 1'b1;
                    r_window     <= '0;
                  end else begin
                    r_hdr_err <= 1'b1;
                    r_armed   <= 1'b0;
                  end
                end
                9'd6:    r_state <= StGap;
                default: ;
              endcase
            end
            StData: begin
              if (!r_byte_cnt[8]) begin
                if (r_armed) begin
                  r_buf_addr <= r_byte_cnt[7:0];
                  r_buf_di   <= w_byte;
                  r_buf_we   <= 1'b1;
                end
                r_cks      <= w_cks_nxt;
                r_byte_cnt <= r_byte_cnt + 9'd1;
              end else begin
                if (r_armed) begin
                  r_data_ok  <= (w_byte == r_cks);
                  r_data_err <= (w_byte != r_cks);
                end
                r_armed <= 1'b0;
                r_state <= StHunt;
              end
            end
            default: begin
              if (r_armed) begin
                r_window <= w_window_inc;
                if (w_window_inc == WinW'(HDR_WINDOW)) r_armed <= 1'b0;
              end
            end
          endcase
        end
      end
    end
  end

  assign o_sync       = r_sync;
  assign o_hdr_ok     = r_hdr_ok;
  assign o_hdr_err    = r_hdr_err;
  assign o_hdr_track  = r_hdr_track;
  assign o_hdr_sector = r_hdr_sector;
  assign o_hdr_id     = r_hdr_id;
  assign o_buf_addr   = r_buf_addr;
  assign o_buf_di     = r_buf_di;
  assign o_buf_we     = r_buf_we;
  assign o_data_ok    = r_data_ok;
  assign o_data_err   = r_data_err;
  assign o_gcr_err    = r_gcr_err;
endmodule

// File: tb/tb_c1541_gcr_decode.sv
// Bench for c1541_gcr_decode: builds GCR track streams from byte-level frames and checks
// decoded headers, buffer writes and status pulses against expectations derived from the frames.
`timescale 1ns/1ps
module tb_c1541_gcr_decode;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        bit_en = 1'b0;
  logic        bit_in = 1'b0;
  logic        o_sync, o_hdr_ok, o_hdr_err, o_buf_we, o_data_ok, o_data_err, o_gcr_err;
  logic [7:0]  o_hdr_track, o_hdr_sector, o_buf_addr, o_buf_di;
  logic [15:0] o_hdr_id;
  logic [54:0] all_o;

  c1541_gcr_decode #(.SYNC_BITS(10), .HDR_WINDOW(32)) dut (
    .i_clk32(clk), .i_reset(rst), .i_enable(en), .i_bit_en(bit_en), .i_bit_in(bit_in),
    .o_sync(o_sync), .o_hdr_ok(o_hdr_ok), .o_hdr_err(o_hdr_err), .o_hdr_track(o_hdr_track),
    .o_hdr_sector(o_hdr_sector), .o_hdr_id(o_hdr_id), .o_buf_addr(o_buf_addr),
    .o_buf_di(o_buf_di), .o_buf_we(o_buf_we), .o_data_ok(o_data_ok), .o_data_err(o_data_err),
    .o_gcr_err(o_gcr_err)
  );

  assign all_o = {o_sync, o_hdr_ok, o_hdr_err, o_hdr_track, o_hdr_sector, o_hdr_id, o_buf_addr,
                  o_buf_di, o_buf_we, o_data_ok, o_data_err, o_gcr_err};

  always #15.625 clk = ~clk;

  int n_vec = 0, n_miss = 0;
  int n_hok = 0, n_herr = 0, n_dok = 0, n_derr = 0, n_gerr = 0;
  int b_hok, b_herr, b_dok, b_derr, b_gerr, b_wr;
  logic [7:0] wr_addr[$];
  logic [7:0] wr_di[$];
  logic [7:0] blk[256];
  logic [7:0] exp_trk, exp_sec;
  logic [15:0] exp_id;

  // Event monitor: tallies pulses and logs every buffer write.
  always @(negedge clk) begin
    if (o_hdr_ok) n_hok++;
    if (o_hdr_err) n_herr++;
    if (o_data_ok) n_dok++;
    if (o_data_err) n_derr++;
    if (o_gcr_err) n_gerr++;
    if (o_buf_we) begin
      wr_addr.push_back(o_buf_addr);
      wr_di.push_back(o_buf_di);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  function automatic logic [4:0] tab5(input logic [3:0] n);
    case (n)
      4'h0: return 5'b01010;  4'h1: return 5'b01011;  4'h2: return 5'b10010;
      4'h3: return 5'b10011;  4'h4: return 5'b01110;  4'h5: return 5'b01111;
      4'h6: return 5'b10110;  4'h7: return 5'b10111;  4'h8: return 5'b01001;
      4'h9: return 5'b11001;  4'hA: return 5'b11010;  4'hB: return 5'b11011;
      4'hC: return 5'b01101;  4'hD: return 5'b11101;  4'hE: return 5'b11110;
      default: return 5'b10101;
    endcase
  endfunction

  function automatic logic [7:0] blk_xor(input int n);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < n; i++) c ^= blk[i];
    return c;
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk);
    bit_en = 1'b1;
    bit_in = b;
    @(negedge clk);
    bit_en = 1'b0;
  endtask

  task automatic send_raw(input logic [9:0] v);
    for (int i = 9; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_raw({tab5(b[7:4]), tab5(b[3:0])});
  endtask

  task automatic send_sync(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  task automatic send_gap(input int n);
    repeat (n) send_byte(8'h55);
  endtask

  task automatic send_header(input logic [7:0] trk, input logic [7:0] sec, input logic [7:0] id1,
                             input logic [7:0] id2, input logic [7:0] flip);
    send_sync(40);
    send_byte(8'h08);
    send_byte(sec ^ trk ^ id2 ^ id1 ^ flip);
    send_byte(sec);
    send_byte(trk);
    send_byte(id2);
    send_byte(id1);
    send_byte(8'h0F);
    send_byte(8'h0F);
  endtask

  // n bytes of blk after the 0x07 marker; a full block adds checksum and two 0x00 trailers.
  task automatic send_data(input int n, input int bad);
    send_sync(40);
    send_byte(8'h07);
    for (int i = 0; i < n; i++) begin
      if (i == bad) send_raw({5'b00000, tab5(blk[i][3:0])});
      else send_byte(blk[i]);
    end
    if (n == 256) begin
      send_byte(blk_xor(256));
      send_byte(8'h00);
      send_byte(8'h00);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic mark();
    b_hok = n_hok; b_herr = n_herr; b_dok = n_dok; b_derr = n_derr; b_gerr = n_gerr;
    b_wr = wr_addr.size();
  endtask

  task automatic rand_header(output logic [7:0] t, output logic [7:0] s, output logic [15:0] id);
    t = 8'($urandom_range(1, 35));
    s = 8'($urandom_range(0, 20));
    id = 16'($urandom);
  endtask

  task automatic test_reset();
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (all_o !== 55'd0) begin
      n_miss++; $display("FAIL reset_outputs: got %h expected 0", all_o);
    end
    idle(3);
    en = 1'b1;
    rst = 1'b0;
    idle(2);
    n_vec++;
    if (all_o !== 55'd0) begin
      n_miss++; $display("FAIL post_reset_idle: got %h expected 0", all_o);
    end
  endtask

  task automatic test_good_header();
    mark();
    send_sync(40);
    n_vec++;
    if (o_sync !== 1'b1) begin n_miss++; $display("FAIL sync_high: got %b expected 1", o_sync); end
    send_header(8'h12, 8'h00, 8'h41, 8'h42, 8'h00);
    idle(2);
    exp_trk = 8'h12; exp_sec = 8'h00; exp_id = 16'h4142;
    n_vec++;
    if (n_hok - b_hok !== 1 || n_herr - b_herr !== 0) begin
      n_miss++; $display("FAIL hdr1_pulses: got ok=%0d err=%0d expected ok=1 err=0",
                         n_hok - b_hok, n_herr - b_herr);
    end
    n_vec++;
    if ({o_hdr_track, o_hdr_sector, o_hdr_id} !== {exp_trk, exp_sec, exp_id}) begin
      n_miss++; $display("FAIL hdr1_fields: got %h %h %h expected %h %h %h", o_hdr_track,
                         o_hdr_sector, o_hdr_id, exp_trk, exp_sec, exp_id);
    end
    n_vec++;
    if (o_sync !== 1'b0) begin n_miss++; $display("FAIL sync_left: got %b expected 0", o_sync); end
  endtask

  task automatic test_bad_header();
    logic [7:0] t, s;
    logic [15:0] id;
    rand_header(t, s, id);
    for (int i = 0; i < 256; i++) blk[i] = 8'($urandom);
    mark();
    send_header(t, s, id[15:8], id[7:0], 8'h01);
    send_gap(8);
    send_data(256, -1);
    idle(2);
    n_vec++;
    if (n_herr - b_herr !== 1 || n_hok - b_hok !== 0) begin
      n_miss++; $display("FAIL hdr_bad_pulses: got ok=%0d err=%0d expected ok=0 err=1",
                         n_hok - b_hok, n_herr - b_herr);
    end
    n_vec++;
    if ({o_hdr_track, o_hdr_sector, o_hdr_id} !== {exp_trk, exp_sec, exp_id}) begin
      n_miss++; $display("FAIL hdr_bad_kept: got %h %h %h expected %h %h %h", o_hdr_track,
                         o_hdr_sector, o_hdr_id, exp_trk, exp_sec, exp_id);
    end
    n_vec++;
    if (wr_addr.size() - b_wr !== 0 || n_dok - b_dok !== 0 || n_derr - b_derr !== 0) begin
      n_miss++; $display("FAIL unarmed_data: got wr=%0d ok=%0d err=%0d expected 0 0 0",
                         wr_addr.size() - b_wr, n_dok - b_dok, n_derr - b_derr);
    end
  endtask

  task automatic test_data_block();
    logic [7:0] t, s;
    logic [15:0] id;
    int bad;
    rand_header(t, s, id);
    for (int i = 0; i < 256; i++) blk[i] = 8'(i);
    mark();
    send_header(t, s, id[15:8], id[7:0], 8'h00);
    send_gap(8);
    send_data(256, -1);
    idle(2);
    exp_trk = t; exp_sec = s; exp_id = id;
    n_vec++;
    if ({o_hdr_track, o_hdr_sector, o_hdr_id} !== {t, s, id}) begin
      n_miss++; $display("FAIL hdr_rand_fields: got %h %h %h expected %h %h %h", o_hdr_track,
                         o_hdr_sector, o_hdr_id, t, s, id);
    end
    n_vec++;
    if (wr_addr.size() - b_wr !== 256) begin
      n_miss++; $display("FAIL data_wr_count: got %0d expected 256", wr_addr.size() - b_wr);
    end
    bad = 0;
    for (int i = 0; i < 256 && b_wr + i < wr_addr.size(); i++)
      if (wr_addr[b_wr + i] !== 8'(i) || wr_di[b_wr + i] !== blk[i]) bad++;
    n_vec++;
    if (bad !== 0) begin n_miss++; $display("FAIL data_wr_content: got %0d bad expected 0", bad); end
    n_vec++;
    if (n_dok - b_dok !== 1 || n_derr - b_derr !== 0 || n_gerr - b_gerr !== 0) begin
      n_miss++; $display("FAIL data_pulses: got ok=%0d err=%0d gcr=%0d expected 1 0 0",
                         n_dok - b_dok, n_derr - b_derr, n_gerr - b_gerr);
    end
  endtask

  task automatic test_sync_abort();
    for (int i = 0; i < 256; i++) blk[i] = 8'(i);
    mark();
    send_header(8'h05, 8'h03, 8'h41, 8'h42, 8'h00);
    send_gap(8);
    send_data(100, -1);
    send_sync(12);
    idle(2);
    n_vec++;
    if (wr_addr.size() - b_wr !== 100) begin
      n_miss++; $display("FAIL abort_wr_count: got %0d expected 100", wr_addr.size() - b_wr);
    end
    n_vec++;
    if (n_derr - b_derr !== 1 || n_dok - b_dok !== 0) begin
      n_miss++; $display("FAIL abort_pulses: got ok=%0d err=%0d expected 0 1",
                         n_dok - b_dok, n_derr - b_derr);
    end
    n_vec++;
    if (o_sync !== 1'b1) begin n_miss++; $display("FAIL abort_sync: got %b expected 1", o_sync); end
  endtask

  task automatic test_gcr_err();
    logic [7:0] dec_x;
    logic exp_ok;
    for (int i = 0; i < 256; i++) blk[i] = 8'($urandom);
    blk[5] = blk[5] | 8'h10;
    // Decoder sees byte 5 with its high nibble as 0; the sent checksum covers the true byte.
    dec_x = blk_xor(256) ^ blk[5] ^ (blk[5] & 8'h0F);
    exp_ok = (dec_x == blk_xor(256));
    mark();
    send_header(8'h11, 8'h07, 8'h30, 8'h31, 8'h00);
    send_gap(8);
    send_data(256, 5);
    idle(2);
    n_vec++;
    if (n_gerr - b_gerr !== 1) begin
      n_miss++; $display("FAIL gcr_pulse: got %0d expected 1", n_gerr - b_gerr);
    end
    n_vec++;
    if (wr_addr.size() - b_wr !== 256) begin
      n_miss++; $display("FAIL gcr_wr_count: got %0d expected 256", wr_addr.size() - b_wr);
    end else if (wr_addr[b_wr + 5] !== 8'd5 || wr_di[b_wr + 5] !== (blk[5] & 8'h0F)) begin
      n_miss++; $display("FAIL gcr_wr_byte5: got %h/%h expected 05/%h", wr_addr[b_wr + 5],
                         wr_di[b_wr + 5], blk[5] & 8'h0F);
    end
    n_vec++;
    if (n_dok - b_dok !== int'(exp_ok) || n_derr - b_derr !== int'(!exp_ok)) begin
      n_miss++; $display("FAIL gcr_data_pulses: got ok=%0d err=%0d expected %0d %0d",
                         n_dok - b_dok, n_derr - b_derr, exp_ok, !exp_ok);
    end
  endtask

  task automatic test_window(input int gap);
    logic acc;
    int bad;
    for (int i = 0; i < 256; i++) blk[i] = 8'($urandom);
    acc = (gap < 32);
    mark();
    send_header(8'h20, 8'h02, 8'h55, 8'hAA, 8'h00);
    send_gap(gap);
    send_data(256, -1);
    idle(2);
    n_vec++;
    if (wr_addr.size() - b_wr !== (acc ? 256 : 0)) begin
      n_miss++; $display("FAIL win%0d_wr_count: got %0d expected %0d", gap,
                         wr_addr.size() - b_wr, acc ? 256 : 0);
    end
    bad = 0;
    for (int i = 0; i < 256 && b_wr + i < wr_addr.size(); i++)
      if (wr_addr[b_wr + i] !== 8'(i) || wr_di[b_wr + i] !== blk[i]) bad++;
    n_vec++;
    if (bad !== 0) begin
      n_miss++; $display("FAIL win%0d_wr_content: got %0d bad expected 0", gap, bad);
    end
    n_vec++;
    if (n_dok - b_dok !== int'(acc) || n_derr - b_derr !== 0) begin
      n_miss++; $display("FAIL win%0d_pulses: got ok=%0d err=%0d expected %0d 0", gap,
                         n_dok - b_dok, n_derr - b_derr, acc);
    end
  endtask

  task automatic test_enable_drop();
    for (int i = 0; i < 256; i++) blk[i] = 8'($urandom);
    mark();
    send_header(8'h09, 8'h04, 8'h12, 8'h34, 8'h00);
    send_gap(4);
    send_data(50, -1);
    @(negedge clk);
    en = 1'b0;
    idle(2);
    en = 1'b1;
    idle(1);
    n_vec++;
    if (wr_addr.size() - b_wr !== 50 || n_derr - b_derr !== 0 || n_dok - b_dok !== 0) begin
      n_miss++; $display("FAIL endrop_state: got wr=%0d ok=%0d err=%0d expected 50 0 0",
                         wr_addr.size() - b_wr, n_dok - b_dok, n_derr - b_derr);
    end
    n_vec++;
    if (o_sync !== 1'b0) begin n_miss++; $display("FAIL endrop_sync: got %b expected 0", o_sync); end
    send_data(20, -1);
    idle(2);
    n_vec++;
    if (wr_addr.size() - b_wr !== 50) begin
      n_miss++; $display("FAIL endrop_disarmed: got %0d expected 50", wr_addr.size() - b_wr);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] t, s;
    logic [15:0] id;
    for (int i = 0; i < 256; i++) blk[i] = 8'($urandom) | 8'h01;
    send_header(8'h21, 8'h0A, 8'h77, 8'h66, 8'h00);
    send_gap(4);
    send_data(30, -1);
    rst = 1'b1;
    #1;
    n_vec++;
    if (all_o !== 55'd0) begin
      n_miss++; $display("FAIL reset_mid_outputs: got %h expected 0", all_o);
    end
    idle(2);
    rst = 1'b0;
    idle(1);
    rand_header(t, s, id);
    mark();
    send_header(t, s, id[15:8], id[7:0], 8'h00);
    idle(2);
    n_vec++;
    if (n_hok - b_hok !== 1 || {o_hdr_track, o_hdr_sector, o_hdr_id} !== {t, s, id}) begin
      n_miss++; $display("FAIL restart_hdr: got ok=%0d %h %h %h expected 1 %h %h %h",
                         n_hok - b_hok, o_hdr_track, o_hdr_sector, o_hdr_id, t, s, id);
    end
  endtask

  initial begin
    test_reset();
    test_good_header();
    test_bad_header();
    test_data_block();
    test_sync_abort();
    test_gcr_err();
    test_window(31);
    test_window(32);
    test_window(40);
    test_enable_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
